// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// Optional feature macro: LOADER_CHECKSUM_EN (adds the trailing checksum byte).
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN0,
    LEN1,
    DATA,
    CHK,
    FLUSH,
    DONE,
    ERR
  } state_e;

  localparam int LEN_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/prog_loader_word_assembler.sv
// Little-endian byte-to-word assembler: shifts bytes in from the top so the
// first byte ends up in bits [7:0], and flags the cycle after the 4th byte.
module word_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_data,
  output logic [1:0]  byte_cnt,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [31:0] shift_q, shift_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        valid_q, valid_d;

  // Next-state for the shift register, byte counter and one-cycle valid pulse.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    if (clear) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (byte_en) begin
      shift_d = {byte_data, shift_q[31:8]};
      cnt_d   = cnt_q + 2'd1;
      valid_d = (cnt_q == 2'(BYTES_PER_WORD - 1));
    end
  end

  // Registers; a reset discards any partially assembled word.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign byte_cnt   = cnt_q;
  assign word_valid = valid_q;
  assign word       = shift_q;

endmodule

// File: rtl/prog_loader.sv
// Boot-time program loader: receives a length-prefixed byte stream, writes
// 32-bit words to consecutive instruction-memory addresses and releases the
// CPU only after the complete image is committed.
// Optional feature macro: LOADER_CHECKSUM_EN (trailing 8-bit checksum byte).
module prog_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              pc_write,
  output logic              busy,
  output logic              done,
  output logic              error
);

  state_e            state_q, state_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [15:0]       n_q, n_d;
  logic [ADDR_W:0]   w_q, w_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              ready_q, ready_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              pc_write_q, pc_write_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        sum_q, sum_d;
`endif

  logic        xfer;
  logic        start_ok;
  logic        asm_en;
  logic [1:0]  byte_cnt;
  logic        word_valid;
  logic [31:0] word;
  logic [15:0] len_word;

  assign xfer     = byte_valid && ready_q;
  assign start_ok = start && (state_q inside {IDLE, DONE, ERR});
  assign asm_en   = xfer && (state_q == DATA);
  assign len_word = {byte_data, len_lo_q};

  word_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .clear      (start_ok),
    .byte_en    (asm_en),
    .byte_data  (byte_data),
    .byte_cnt   (byte_cnt),
    .word_valid (word_valid),
    .word       (word)
  );

  // Session FSM next state plus counters; outputs are decoded from the next
  // state so they are registered alongside it.
  always_comb begin
    state_d  = state_q;
    len_lo_d = len_lo_q;
    n_d      = n_q;
    w_d      = w_q;
    addr_d   = addr_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d    = sum_q;
`endif
    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d = LEN0;
          n_d     = '0;
          w_d     = '0;
`ifdef LOADER_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end
      LEN0: begin
        if (xfer) begin
          len_lo_d = byte_data;
          state_d  = LEN1;
        end
      end
      LEN1: begin
        if (xfer) begin
          n_d = len_word;
          if (len_word == 16'd0) begin
            state_d = FLUSH;
          end else if (32'(len_word) > 32'(MAX_WORDS)) begin
            state_d = ERR;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (xfer) begin
`ifdef LOADER_CHECKSUM_EN
          sum_d = sum_q + byte_data;
`endif
          if (byte_cnt == 2'(BYTES_PER_WORD - 1)) begin
            addr_d = w_q[ADDR_W-1:0];
            w_d    = w_q + 1'b1;
            if (32'(w_q) + 32'd1 == 32'(n_q)) begin
`ifdef LOADER_CHECKSUM_EN
              state_d = CHK;
`else
              state_d = FLUSH;
`endif
            end
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHK: begin
        if (xfer) begin
          state_d = (sum_q + byte_data == 8'h00) ? FLUSH : ERR;
        end
      end
`endif
      FLUSH:   state_d = DONE;
      default: state_d = IDLE;
    endcase

    ready_d     = state_d inside {LEN0, LEN1, DATA, CHK};
    busy_d      = state_d inside {LEN0, LEN1, DATA, CHK, FLUSH};
    done_d      = (state_d == DONE);
    error_d     = (state_d == ERR);
    cpu_reset_d = (state_d != DONE);
    pc_write_d  = (state_d == DONE);
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      len_lo_q    <= '0;
      n_q         <= '0;
      w_q         <= '0;
      addr_q      <= '0;
      ready_q     <= 1'b0;
      cpu_reset_q <= 1'b1;
      pc_write_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      len_lo_q    <= len_lo_d;
      n_q         <= n_d;
      w_q         <= w_d;
      addr_q      <= addr_d;
      ready_q     <= ready_d;
      cpu_reset_q <= cpu_reset_d;
      pc_write_q  <= pc_write_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  assign byte_ready = ready_q;
  assign imem_we    = word_valid;
  assign imem_addr  = addr_q;
  assign imem_wdata = word;
  assign cpu_reset  = cpu_reset_q;
  assign pc_write   = pc_write_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule
